// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory bus types plus the RAM responder's latency limits and FSM states.
package cpu_types_pkg;

    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;

    // Memory bus status returned by the RAM to the memory controller.
    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    // Largest supported access latency and the counter width needed to hold it.
    localparam int RAM_LAT_MAX   = 15;
    localparam int RAM_LAT_CNT_W = 4;
    typedef logic [RAM_LAT_CNT_W-1:0] lat_cnt_t;

    // Responder transaction FSM.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } rsp_state_t;

endpackage

// File: rtl/ram_responder_array.sv
// Single-port word storage: synchronous write, registered read, contents not reset.
module ram_array
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    word_t mem [2**ADDR_W];

    // Write port: one word per cycle when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read port: output register only updates on an enabled read, so it holds the last read word.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/ram_responder.sv
// RAM bus responder: latches a request, stays BUSY for LAT cycles, then gives one ACCESS cycle.
module ram_responder
    import cpu_types_pkg::*;
#(
    parameter int LAT    = 2,   // legal 1..RAM_LAT_MAX
    parameter int ADDR_W = 10
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ramREN,
    input  logic              ramWEN,
    input  logic [WORD_W-1:0] ramaddr,
    input  logic [WORD_W-1:0] ramstore,
    output logic [WORD_W-1:0] ramload,
    output ramstate_t         ramstate
);

    // Counter holds the number of BUSY cycles still to go after the current one.
    localparam lat_cnt_t LAT_RELOAD = lat_cnt_t'(LAT - 1);
    localparam lat_cnt_t CNT_LAST   = lat_cnt_t'(1);

    rsp_state_t        state_reg;
    lat_cnt_t          cnt_reg;
    logic [ADDR_W-1:0] idx_reg;
    logic              ren_reg;
    logic              wen_reg;
    word_t             data_reg;
    logic              loaded_reg;

    logic              req;
    logic              illegal;
    logic              changed;
    logic              finish;
    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] idx;
    word_t             rdata;

    assign req     = ramREN | ramWEN;
    assign idx     = ramaddr[ADDR_W+1:2];
    assign illegal = (ramREN & ramWEN) | (req & (ramaddr[WORD_W-1:ADDR_W+2] != '0));

    // Any difference from the latched request restarts the wait; store data only matters for writes.
    assign changed = (idx != idx_reg) | (ramREN != ren_reg) | (ramWEN != wen_reg)
                   | (ramWEN & (ramstore != data_reg));

    // The access happens on the edge into DONE; the live inputs equal the latched request here.
    assign finish = req & ~illegal &
                    (((state_reg == IDLE) & (LAT == 1)) |
                     ((state_reg == WAIT) & ~changed & (cnt_reg == CNT_LAST)));

    // Gated by nRST so a request held during reset can never touch the array.
    assign mem_we = nRST & finish & ramWEN;
    assign mem_re = nRST & finish & ramREN;

    ram_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (CLK),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (idx),
        .wdata (ramstore),
        .rdata (rdata)
    );

    // Bus status: ERROR overrides everything; otherwise reflects FSM state and request presence.
    always_comb begin
        ramstate = FREE;
        if (illegal) begin
            ramstate = ERROR;
        end else begin
            case (state_reg)
                IDLE:    ramstate = req ? BUSY : FREE;
                WAIT:    ramstate = req ? BUSY : FREE;
                DONE:    ramstate = ACCESS;
                default: ramstate = FREE;
            endcase
        end
    end

    // Read data is zero until the first read after reset, and forced to zero on an illegal request.
    assign ramload = (illegal | ~loaded_reg) ? '0 : rdata;

    // Transaction FSM with request latch and latency counter.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            idx_reg    <= '0;
            ren_reg    <= 1'b0;
            wen_reg    <= 1'b0;
            data_reg   <= '0;
            loaded_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req && !illegal) begin
                        idx_reg   <= idx;
                        ren_reg   <= ramREN;
                        wen_reg   <= ramWEN;
                        data_reg  <= ramstore;
                        cnt_reg   <= LAT_RELOAD;
                        state_reg <= (LAT == 1) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (illegal || !req) begin
                        state_reg <= IDLE;
                    end else if (changed) begin
                        // Restart: this cycle becomes BUSY cycle 1 of the new request.
                        idx_reg  <= idx;
                        ren_reg  <= ramREN;
                        wen_reg  <= ramWEN;
                        data_reg <= ramstore;
                        cnt_reg  <= LAT_RELOAD;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
            if (mem_re) begin
                loaded_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: one LAT=2 instance and one LAT=3 instance, separate stimulus.
module tb_ram_responder;
    import cpu_types_pkg::*;

    logic        clk;
    logic        nrst;

    logic        ren_a, wen_a;
    logic [31:0] addr_a, store_a, load_a;
    ramstate_t   state_a;

    logic        ren_b, wen_b;
    logic [31:0] addr_b, store_b, load_b;
    ramstate_t   state_b;

    int n_assert = 0;
    int n_fail   = 0;

    ram_responder #(.LAT(2), .ADDR_W(10)) u_lat2 (
        .CLK      (clk),
        .nRST     (nrst),
        .ramREN   (ren_a),
        .ramWEN   (wen_a),
        .ramaddr  (addr_a),
        .ramstore (store_a),
        .ramload  (load_a),
        .ramstate (state_a)
    );

    ram_responder #(.LAT(3), .ADDR_W(10)) u_lat3 (
        .CLK      (clk),
        .nRST     (nrst),
        .ramREN   (ren_b),
        .ramWEN   (wen_b),
        .ramaddr  (addr_b),
        .ramstore (store_b),
        .ramload  (load_b),
        .ramstate (state_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_a(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        ren_a = r; wen_a = w; addr_a = a; store_a = d;
    endtask

    task automatic set_b(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        ren_b = r; wen_b = w; addr_b = a; store_b = d;
    endtask

    // Full LAT=3 transaction on the second instance: 3 BUSY, 1 ACCESS, then FREE once dropped.
    task automatic xact_b(input string tag, input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_load, input bit do_load);
        @(negedge clk); set_b(r, w, a, d); #2;
        chk({tag, " busy1"}, 32'(state_b), 32'(BUSY));
        @(negedge clk); #2;
        chk({tag, " busy2"}, 32'(state_b), 32'(BUSY));
        @(negedge clk); #2;
        chk({tag, " busy3"}, 32'(state_b), 32'(BUSY));
        @(negedge clk); #2;
        chk({tag, " access"}, 32'(state_b), 32'(ACCESS));
        if (do_load) chk({tag, " load"}, load_b, exp_load);
        @(negedge clk); set_b(1'b0, 1'b0, 32'h0, 32'h0); #2;
        chk({tag, " free"}, 32'(state_b), 32'(FREE));
        $display("txn %s r=%0b w=%0b addr=%h data=%h load=%h", tag, r, w, a, d, load_b);
    endtask

    initial begin
        nrst = 1'b0;
        set_a(1'b0, 1'b0, 32'h0, 32'h0);
        set_b(1'b0, 1'b0, 32'h0, 32'h0);

        // 1: reset held for three cycles, then released with no request
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #2;
            chk("rst state a", 32'(state_a), 32'(FREE));
            chk("rst load a", load_a, 32'h0);
            chk("rst state b", 32'(state_b), 32'(FREE));
            chk("rst load b", load_b, 32'h0);
        end
        @(negedge clk); nrst = 1'b1; #2;
        chk("post-rst state a", 32'(state_a), 32'(FREE));
        chk("post-rst state b", 32'(state_b), 32'(FREE));

        // 2: LAT=2 write then read, read held past ACCESS restarts with full latency
        @(negedge clk); set_a(1'b0, 1'b1, 32'h10, 32'hDEADBEEF); #2;
        chk("t2 wr c0", 32'(state_a), 32'(BUSY));
        @(negedge clk); #2;
        chk("t2 wr c1", 32'(state_a), 32'(BUSY));
        @(negedge clk); #2;
        chk("t2 wr c2", 32'(state_a), 32'(ACCESS));
        @(negedge clk); set_a(1'b0, 1'b0, 32'h0, 32'h0); #2;
        chk("t2 wr c3", 32'(state_a), 32'(FREE));
        $display("txn t2 write addr=00000010 data=deadbeef");
        @(negedge clk); set_a(1'b1, 1'b0, 32'h10, 32'h0); #2;
        chk("t2 rd c0", 32'(state_a), 32'(BUSY));
        @(negedge clk); #2;
        chk("t2 rd c1", 32'(state_a), 32'(BUSY));
        @(negedge clk); #2;
        chk("t2 rd c2", 32'(state_a), 32'(ACCESS));
        chk("t2 rd load", load_a, 32'hDEADBEEF);
        @(negedge clk); #2;
        chk("t2 rehold c3", 32'(state_a), 32'(BUSY));
        @(negedge clk); #2;
        chk("t2 rehold c4", 32'(state_a), 32'(BUSY));
        @(negedge clk); #2;
        chk("t2 rehold c5", 32'(state_a), 32'(ACCESS));
        chk("t2 rehold load", load_a, 32'hDEADBEEF);
        @(negedge clk); set_a(1'b0, 1'b0, 32'h0, 32'h0); #2;
        chk("t2 rd free", 32'(state_a), 32'(FREE));
        chk("t2 load hold", load_a, 32'hDEADBEEF);
        $display("txn t2 read addr=00000010 load=%h", load_a);

        // Preload LAT=3 instance with known words
        xact_b("pre w0",  1'b0, 1'b1, 32'h00, 32'hA5A5A5A5, 32'h0, 1'b0);
        xact_b("pre w20", 1'b0, 1'b1, 32'h20, 32'h11111111, 32'h0, 1'b0);
        xact_b("pre w24", 1'b0, 1'b1, 32'h24, 32'h22222222, 32'h0, 1'b0);
        xact_b("pre w40", 1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0);
        xact_b("pre w80", 1'b0, 1'b1, 32'h80, 32'h0BADF00D, 32'h0, 1'b0);

        // 3: address change during WAIT restarts the latency count
        @(negedge clk); set_b(1'b1, 1'b0, 32'h20, 32'h0); #2;
        chk("t3 c0", 32'(state_b), 32'(BUSY));
        @(negedge clk); set_b(1'b1, 1'b0, 32'h24, 32'h0); #2;
        chk("t3 chg busy1", 32'(state_b), 32'(BUSY));
        @(negedge clk); #2;
        chk("t3 chg busy2", 32'(state_b), 32'(BUSY));
        @(negedge clk); #2;
        chk("t3 chg busy3", 32'(state_b), 32'(BUSY));
        @(negedge clk); #2;
        chk("t3 access", 32'(state_b), 32'(ACCESS));
        chk("t3 load", load_b, 32'h22222222);
        @(negedge clk); set_b(1'b0, 1'b0, 32'h0, 32'h0); #2;
        chk("t3 free", 32'(state_b), 32'(FREE));
        $display("txn t3 read 20->24 load=%h", load_b);

        // 4: write abandoned by dropping ramWEN leaves the old word
        @(negedge clk); set_b(1'b0, 1'b1, 32'h40, 32'h12345678); #2;
        chk("t4 c0", 32'(state_b), 32'(BUSY));
        @(negedge clk); set_b(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk); #2;
        chk("t4 free", 32'(state_b), 32'(FREE));
        $display("txn t4 aborted write addr=00000040");
        xact_b("t4 rd40", 1'b1, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D, 1'b1);

        // 5: out-of-range address and REN&WEN both give ERROR with no write
        @(negedge clk); set_b(1'b1, 1'b0, 32'h00001000, 32'h0); #2;
        chk("t5 oor state", 32'(state_b), 32'(ERROR));
        chk("t5 oor load", load_b, 32'h0);
        @(negedge clk); set_b(1'b0, 1'b0, 32'h0, 32'h0); #2;
        chk("t5 oor free", 32'(state_b), 32'(FREE));
        chk("t5 load restored", load_b, 32'hCAFEF00D);
        @(negedge clk); set_b(1'b1, 1'b1, 32'h0, 32'hFFFFFFFF); #2;
        chk("t5 both state", 32'(state_b), 32'(ERROR));
        chk("t5 both load", load_b, 32'h0);
        $display("txn t5 illegal requests");
        xact_b("t5 rd0", 1'b1, 1'b0, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b1);

        // 6: reset during WAIT of a write abandons it; re-presented write lands
        @(negedge clk); set_b(1'b0, 1'b1, 32'h80, 32'h55AA55AA); #2;
        chk("t6 c0", 32'(state_b), 32'(BUSY));
        @(negedge clk); #2;
        chk("t6 c1", 32'(state_b), 32'(BUSY));
        @(negedge clk); nrst = 1'b0; set_b(1'b0, 1'b0, 32'h0, 32'h0); #2;
        chk("t6 rst state", 32'(state_b), 32'(FREE));
        chk("t6 rst load", load_b, 32'h0);
        @(negedge clk); nrst = 1'b1; #2;
        chk("t6 rel state", 32'(state_b), 32'(FREE));
        $display("txn t6 reset during write addr=00000080");
        xact_b("t6 rd80 old", 1'b1, 1'b0, 32'h80, 32'h0, 32'h0BADF00D, 1'b1);
        xact_b("t6 wr80", 1'b0, 1'b1, 32'h80, 32'h55AA55AA, 32'h0, 1'b0);
        xact_b("t6 rd80 new", 1'b1, 1'b0, 32'h80, 32'h0, 32'h55AA55AA, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Memory-side responder for the ram bus driven by the memory controller: consumes ramREN/ramWEN/ramaddr/ramstore and returns ramstate/ramload.
- Holds a word-addressed storage array with a configurable access latency, so arbitration, iwait/dwait and cache stall logic are exercised against realistic BUSY/ACCESS timing.
- Sits below the memory controller in the system/testbench top; one instance per system.

Parameters:
- LAT, 2, access latency in cycles; legal 1..15. ramstate is BUSY for exactly LAT cycles before ACCESS.
- ADDR_W, 10, word-index width; the array holds 2**ADDR_W 32-bit words.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- ramREN  input  1  read request.
- ramWEN  input  1  write request.
- ramaddr  input  32  byte address; bits [1:0] ignored.
- ramstore  input  32  write data.
- ramload  output  32  read data; valid only while ramstate==ACCESS for a read.
- ramstate  output  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.

Behaviour:
- Reset: state IDLE, counter 0, latched request cleared, ramload=0, so ramstate=FREE with no request. Array contents are not reset. Reset mid-transaction abandons it and performs no write.
- req = ramREN|ramWEN. illegal = (ramREN&ramWEN) | (req & ramaddr[31:ADDR_W+2]!=0).
- ERROR: ramstate=ERROR combinationally in any cycle where illegal=1. Next state is IDLE. No write occurs, and ramload is forced to 0.
- FSM states are IDLE, WAIT and DONE.
- IDLE:
  - ramstate=FREE if !req, else BUSY.
  - On a legal req, latch addr index, op and ramstore, load the counter, then go to WAIT, or to DONE if LAT==1.
- WAIT:
  - ramstate=BUSY; the counter decrements each cycle.
  - After the LAT-th BUSY cycle (the request cycle counts as the first), go to DONE.
- Entering DONE (edge):
  - Read: ramload <= mem[idx].
  - Write: mem[idx] <= ramstore.
- DONE: ramstate=ACCESS for exactly one cycle, then IDLE unconditionally. A request still present in the following IDLE cycle starts a new transaction with the full LAT BUSY cycles again.
- Request change in WAIT:
  - If ramaddr, ramREN, ramWEN, or (for writes) ramstore differs from the latched value, the transaction restarts. The new values are latched, the counter reloads, and that cycle counts as BUSY cycle 1.
  - If req drops in WAIT, go to IDLE with no write.
- ramload holds its last captured value outside ACCESS, except that it is 0 under ERROR. Consumers must qualify it with ACCESS.
- Timing: one transaction takes LAT+1 cycles; back-to-back transactions take LAT+1 each.

Decomposition:
- ramstate_t, word_t and WORD_W come from cpu_types_pkg.
- Add RAM_LAT_MAX=15 and the latency counter width (4) to the same package.
- One sub-module, ram_array: a 2**ADDR_W x 32 synchronous-write, registered-read storage with a single port. It is not reset.
- The FSM, request latch, compare and counter live in ram_responder.

Test Plan:
1. Hold nRST=0 for 3 cycles -> ramstate=FREE, ramload=0 throughout; release with no request -> FREE.
2. LAT=2: write 0x00000010 with data 0xDEADBEEF, held -> BUSY in cycles 0-1, ACCESS in cycle 2, FREE in cycle 3. Then read 0x10 -> BUSY x2, then ACCESS with ramload=0xDEADBEEF.
3. LAT=3: read 0x20 for 1 cycle, then change to 0x24 and hold -> BUSY for 3 cycles counted from the change, then ACCESS with ramload=mem[9] (not mem[8]).
4. LAT=3: write 0x40 with data 0x12345678, drop ramWEN after 1 cycle -> FREE next cycle; a later read of 0x40 returns the old value.
5. ADDR_W=10: read 0x00001000 -> ERROR in the same cycle, ramload=0. Assert ramREN&ramWEN at 0x0 -> ERROR, no write. A following legal read of 0x0 gets normal timing.
6. Pulse nRST low during WAIT of a write to 0x80 -> FREE immediately, no write. Re-present the request -> full LAT BUSY cycles, then ACCESS, and the write lands.
